// File: rtl/uart_seq_pkg.sv
// Shared definitions for the UART APB sequencer.
// Contents:
//   - APB register addresses of the UART slave
//   - CTRL values written during a transfer
//   - STATS bit positions
//   - Sequencer FSM states and APB access phases
//   - Access command struct with small constructors
package uart_seq_pkg;

  localparam logic [31:0] ADDR_CTRL    = 32'd0;
  localparam logic [31:0] ADDR_STATS   = 32'd1;
  localparam logic [31:0] ADDR_TX_DATA = 32'd2;
  localparam logic [31:0] ADDR_RX_DATA = 32'd3;

  // CTRL: bit0 rx_en, bit1 rx_rst, bit2 tx_rst, bit3 tx_en
  localparam logic [31:0] CTRL_RESET   = 32'h6;
  localparam logic [31:0] CTRL_ENABLE  = 32'h9;
  localparam logic [31:0] CTRL_DISABLE = 32'h0;

  localparam int STAT_TX_BUSY = 0;
  localparam int STAT_TX_DONE = 1;
  localparam int STAT_RX_BUSY = 2;
  localparam int STAT_RX_DONE = 3;
  localparam int STAT_RX_ERR  = 4;

  typedef enum logic [2:0] {
    IDLE, WR_RST, WR_DATA, WR_EN, POLL, RD_RX, WR_DIS, RESP
  } seq_state_e;

  typedef enum logic [1:0] {
    PH_IDLE, PH_SETUP, PH_ACCESS, PH_SAMPLE
  } apb_phase_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } apb_cmd_t;

  function automatic apb_cmd_t apb_wr(input logic [31:0] addr, input logic [31:0] wdata);
    apb_cmd_t c;
    c.addr  = addr;
    c.write = 1'b1;
    c.wdata = wdata;
    return c;
  endfunction

  function automatic apb_cmd_t apb_rd(input logic [31:0] addr);
    apb_cmd_t c;
    c.addr  = addr;
    c.write = 1'b0;
    c.wdata = 32'd0;
    return c;
  endfunction

endpackage

// File: rtl/uart_apb_sequencer_if.sv
// APB bus between the sequencer (master) and the UART register slave.
// Signals: PADDR, PSEL, PENABLE, PWRITE, PWDATA (master -> slave);
//          PRDATA, PREADY (slave -> master).
interface uart_apb_sequencer_if;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA, input PRDATA, PREADY);
  modport slave  (input PADDR, PSEL, PENABLE, PWRITE, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/apb_master_if.sv
// Single APB access engine: one SETUP cycle, ACCESS until PREADY, then a
// SAMPLE cycle in which the slave's late read data is valid.
// Ports:
//   PCLK, PRESETn    clock, synchronous active-low reset
//   start            begin an access (accepted only when idle)
//   addr/write/wdata access command, captured on start and held to SAMPLE
//   done             high during the SAMPLE cycle
//   rdata            read data, valid while done is high
//   apb              APB master modport
module apb_master_if
  import uart_seq_pkg::*;
(
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  uart_apb_sequencer_if.master apb
);

  apb_phase_e phase;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values, independent of statement order.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      phase       <= PH_IDLE;
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
    end else begin
      case (phase)
        PH_IDLE: if (start) begin
          apb.PSEL    <= 1'b1;
          apb.PENABLE <= 1'b0;
          apb.PADDR   <= addr;
          apb.PWRITE  <= write;
          apb.PWDATA  <= wdata;
          phase       <= PH_SETUP;
        end
        PH_SETUP: begin
          apb.PENABLE <= 1'b1;
          phase       <= PH_ACCESS;
        end
        PH_ACCESS: if (apb.PREADY) begin
          apb.PSEL    <= 1'b0;
          apb.PENABLE <= 1'b0;
          phase       <= PH_SAMPLE;
        end
        default: phase <= PH_IDLE;  // PH_SAMPLE: PADDR/PWRITE/PWDATA still held
      endcase
    end
  end

  // The slave registers read data, so PRDATA is meaningful only in SAMPLE.
  assign done  = (phase == PH_SAMPLE);
  assign rdata = apb.PRDATA;

endmodule

// File: rtl/uart_apb_sequencer.sv
// Two-requester UART transfer sequencer over APB. A granted requester's byte
// is pushed through the UART (reset, load TX, enable, poll STATS, read RX,
// disable) and a one-cycle response reports the received byte or an error.
// Ports:
//   PCLK, PRESETn          clock, synchronous active-low reset
//   req[1:0], req_data     level requests, byte per requester
//   gnt[1:0]               one-hot grant pulse
//   rsp_*                  one-cycle response (id, data, err, timeout)
//   busy                   high whenever the FSM is not IDLE
//   apb                    APB master to the UART slave
// Configuration: define UART_SEQ_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
module uart_apb_sequencer
  import uart_seq_pkg::*;
#(
  parameter logic [15:0] POLL_TIMEOUT = 16'd1000
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [1:0]  req,
  input  logic [15:0] req_data,
  output logic [1:0]  gnt,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  uart_apb_sequencer_if.master apb
);

  seq_state_e  state;
  apb_cmd_t    cmd;
  logic        start;
  logic        done;
  logic [31:0] rdata;
  logic        id_q;
  logic [7:0]  tx_byte;
  logic [7:0]  rx_byte;
  logic        err_q;
  logic        tmo_q;
  logic [15:0] poll_cnt;
  logic [15:0] poll_next;
  logic        sel;
  logic        rdata_unused;

  assign poll_next    = poll_cnt + 16'd1;
  assign rdata_unused = ^rdata[31:8];

`ifdef UART_SEQ_RR_EN
  logic last_gnt;

  // NOTE: combinational blocks assign every output up front so no path
  // leaves a value unassigned, which would infer a latch.
  always_comb begin
    sel = ~req[0];
    if (req == 2'b11) sel = ~last_gnt;
  end
`else
  always_comb begin
    sel = ~req[0];
  end
`endif

  apb_master_if u_apb (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .start   (start),
    .addr    (cmd.addr),
    .write   (cmd.write),
    .wdata   (cmd.wdata),
    .done    (done),
    .rdata   (rdata),
    .apb     (apb)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state       <= IDLE;
      gnt         <= '0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      start       <= 1'b0;
      cmd         <= '0;
      id_q        <= 1'b0;
      tx_byte     <= '0;
      rx_byte     <= '0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
      poll_cnt    <= '0;
`ifdef UART_SEQ_RR_EN
      last_gnt    <= 1'b1;
`endif
    end else begin
      gnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      start       <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          gnt      <= sel ? 2'b10 : 2'b01;
          id_q     <= sel;
          tx_byte  <= sel ? req_data[15:8] : req_data[7:0];
          rx_byte  <= '0;
          err_q    <= 1'b0;
          tmo_q    <= 1'b0;
          poll_cnt <= '0;
          busy     <= 1'b1;
          cmd      <= apb_wr(ADDR_CTRL, CTRL_RESET);
          start    <= 1'b1;  // SETUP follows the gnt cycle
          state    <= WR_RST;
`ifdef UART_SEQ_RR_EN
          last_gnt <= sel;
`endif
        end
        WR_RST: if (done) begin
          cmd   <= apb_wr(ADDR_TX_DATA, {24'b0, tx_byte});
          start <= 1'b1;
          state <= WR_DATA;
        end
        WR_DATA: if (done) begin
          cmd   <= apb_wr(ADDR_CTRL, CTRL_ENABLE);
          start <= 1'b1;
          state <= WR_EN;
        end
        WR_EN: if (done) begin
          cmd   <= apb_rd(ADDR_STATS);
          start <= 1'b1;
          state <= POLL;
        end
        POLL: if (done) begin
          poll_cnt <= poll_next;
          start    <= 1'b1;
          // rx_err outranks rx_done; timeout only when neither flag is set.
          if (rdata[STAT_RX_ERR]) begin
            err_q <= 1'b1;
            cmd   <= apb_wr(ADDR_CTRL, CTRL_DISABLE);
            state <= WR_DIS;
          end else if (rdata[STAT_RX_DONE]) begin
            cmd   <= apb_rd(ADDR_RX_DATA);
            state <= RD_RX;
          end else if (poll_next == POLL_TIMEOUT) begin
            tmo_q <= 1'b1;
            cmd   <= apb_wr(ADDR_CTRL, CTRL_DISABLE);
            state <= WR_DIS;
          end
        end
        RD_RX: if (done) begin
          rx_byte <= rdata[7:0];
          cmd     <= apb_wr(ADDR_CTRL, CTRL_DISABLE);
          start   <= 1'b1;
          state   <= WR_DIS;
        end
        WR_DIS: if (done) begin
          rsp_valid   <= 1'b1;
          rsp_id      <= id_q;
          rsp_data    <= (err_q || tmo_q) ? 8'h00 : rx_byte;
          rsp_err     <= err_q;
          rsp_timeout <= tmo_q;
          state       <= RESP;
        end
        default: begin  // RESP
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Scoreboard bench for uart_apb_sequencer against a behavioural UART slave.
module tb_uart_apb_sequencer;

  localparam int EV_GNT = 0;
  localparam int EV_WR  = 1;
  localparam int EV_RD  = 2;
  localparam int EV_RSP = 3;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  logic        PCLK;
  logic        PRESETn;
  logic [1:0]  req;
  logic [15:0] req_data;
  logic [1:0]  gnt;
  logic        rsp_valid;
  logic        rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;

  uart_apb_sequencer_if bus ();

  uart_apb_sequencer #(.POLL_TIMEOUT(16'd4)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .apb         (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;
  ev_t exp_q[$];

  // ---------------- UART slave model ----------------
  // slave_mode 0: loopback, rx_done on the third STATS read after enable
  // slave_mode 1: STATS stuck at 0
  // slave_mode 2: STATS = 0x18 (rx_done and rx_err)
  int         slave_mode  = 0;
  int         wait_states = 0;
  int         wcnt        = 0;
  int         polls       = 0;
  logic [7:0] tx_reg      = 8'h00;

  function automatic logic [31:0] stats_value();
    if (slave_mode == 0) return (polls >= 2) ? 32'h0A : 32'h01;
    if (slave_mode == 1) return 32'h00;
    return 32'h18;
  endfunction

  initial begin
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hDEAD_BEEF;
  end

  always @(posedge PCLK) begin
    bus.PREADY <= 1'b0;
    if (bus.PSEL && !bus.PENABLE) wcnt <= wait_states;
    else if (bus.PSEL && bus.PENABLE && !bus.PREADY) begin
      if (wcnt == 0) bus.PREADY <= 1'b1;
      else wcnt <= wcnt - 1;
    end
    // Read data appears one cycle after PREADY; garbage otherwise.
    if (bus.PSEL && bus.PENABLE && bus.PREADY) begin
      bus.PRDATA <= 32'h0;
      if (bus.PWRITE) begin
        if (bus.PADDR == 32'd2) tx_reg <= bus.PWDATA[7:0];
        if (bus.PADDR == 32'd0 && bus.PWDATA == 32'd9) polls <= 0;
      end else if (bus.PADDR == 32'd1) begin
        bus.PRDATA <= stats_value();
        polls      <= polls + 1;
      end else if (bus.PADDR == 32'd3) begin
        bus.PRDATA <= {24'b0, tx_reg};
      end
    end else begin
      bus.PRDATA <= 32'hDEAD_BEEF;
    end
  end

  // ---------------- scoreboard ----------------
  function automatic string kname(input int k);
    case (k)
      EV_GNT:  return "gnt";
      EV_WR:   return "apb_wr";
      EV_RD:   return "apb_rd";
      default: return "rsp";
    endcase
  endfunction

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  // mode: 0 loopback, 1 timeout, 2 rx_err
  task automatic push_txn(input logic id, input logic [7:0] byte_v, input int mode);
    int nreads;
    nreads = (mode == 0) ? 3 : (mode == 1) ? 4 : 1;
    push(EV_GNT, id ? 32'd2 : 32'd1, 32'd0);
    push(EV_WR, 32'd0, 32'h6);
    push(EV_WR, 32'd2, {24'b0, byte_v});
    push(EV_WR, 32'd0, 32'h9);
    repeat (nreads) push(EV_RD, 32'd1, 32'd0);
    if (mode == 0) push(EV_RD, 32'd3, 32'd0);
    push(EV_WR, 32'd0, 32'h0);
    push(EV_RSP, {29'b0, id, (mode == 2), (mode == 1)}, (mode == 0) ? {24'b0, byte_v} : 32'd0);
  endtask

  task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: got a=%h b=%h, expected no event", kname(kind), a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != a || e.b != b) begin
        bad++;
        $display("FAIL event_%s: got %s a=%h b=%h, want %s a=%h b=%h",
                 kname(e.kind), kname(kind), a, b, kname(e.kind), e.a, e.b);
      end
    end
  endtask

  logic gnt_prev = 1'b0;

  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (gnt_prev) begin
        total++;
        if (!(bus.PSEL && !bus.PENABLE)) begin
          bad++;
          $display("FAIL gnt_to_setup: got PSEL=%b PENABLE=%b, want 1 0", bus.PSEL, bus.PENABLE);
        end
      end
      gnt_prev = (gnt != 2'b00);
      if (gnt != 2'b00) observe(EV_GNT, {30'b0, gnt}, 32'd0);
      if (bus.PSEL && bus.PENABLE && bus.PREADY)
        observe(bus.PWRITE ? EV_WR : EV_RD, bus.PADDR, bus.PWRITE ? bus.PWDATA : 32'd0);
      if (rsp_valid) observe(EV_RSP, {29'b0, rsp_id, rsp_err, rsp_timeout}, {24'b0, rsp_data});
    end else begin
      gnt_prev = 1'b0;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic run_until_rsp(input int n);
    int seen = 0;
    for (int c = 0; c < 3000 && seen < n; c++) begin
      @(negedge PCLK);
      if (rsp_valid) begin
        seen++;
        if (seen == n) req = 2'b00;
      end
    end
    req = 2'b00;
    check("rsp_count", seen, n);
  endtask

  task automatic wait_drain();
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < 500) begin
      @(negedge PCLK);
      c++;
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  hits;
    bit  found;
    PRESETn  = 1'b0;
    req      = 2'b00;
    req_data = 16'h0000;
    repeat (3) @(negedge PCLK);

    check("rst_gnt", {30'b0, gnt}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_rsp", {28'b0, rsp_valid, rsp_id, rsp_err, rsp_timeout}, 0);
    check("rst_rsp_data", {24'b0, rsp_data}, 0);
    check("rst_psel", {29'b0, bus.PSEL, bus.PENABLE, bus.PWRITE}, 0);
    check("rst_paddr", bus.PADDR, 0);
    check("rst_pwdata", bus.PWDATA, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Arbitration with both requests held.
    slave_mode  = 0;
    wait_states = 1;
    req_data    = 16'hB2A1;
`ifdef UART_SEQ_RR_EN
    hits = 4;
    for (int i = 0; i < 4; i++) push_txn(i[0], i[0] ? 8'hB2 : 8'hA1, 0);
`else
    hits = 3;
    for (int i = 0; i < 3; i++) push_txn(1'b0, 8'hA1, 0);
`endif
    req = 2'b11;
    run_until_rsp(hits);
    wait_drain();

    // Loopback transfer of 0xA5 from requester 0.
    wait_states = 0;
    req_data    = 16'h00A5;
    push_txn(1'b0, 8'hA5, 0);
    req = 2'b01;
    run_until_rsp(1);
    wait_drain();

    // STATS stuck at zero: timeout after POLL_TIMEOUT reads.
    slave_mode  = 1;
    wait_states = 2;
    req_data    = 16'h3C00;
    push_txn(1'b1, 8'h3C, 1);
    req = 2'b10;
    run_until_rsp(1);
    wait_drain();

    // rx_err together with rx_done: error wins, no RX read.
    slave_mode  = 2;
    wait_states = 0;
    req_data    = 16'h005A;
    push_txn(1'b0, 8'h5A, 2);
    req = 2'b01;
    run_until_rsp(1);
    wait_drain();

    // Reset during the WR_EN access.
    slave_mode  = 0;
    wait_states = 1;
    req_data    = 16'h0044;
    push(EV_GNT, 32'd1, 32'd0);
    push(EV_WR, 32'd0, 32'h6);
    push(EV_WR, 32'd2, 32'h44);
    req   = 2'b01;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge PCLK);
      if (bus.PSEL && !bus.PENABLE && bus.PADDR == 32'd0 && bus.PWDATA == 32'd9) found = 1'b1;
    end
    check("wr_en_seen", {31'b0, found}, 1);
    PRESETn = 1'b0;
    req     = 2'b00;
    @(negedge PCLK);
    check("midrst_psel", {31'b0, bus.PSEL}, 0);
    check("midrst_penable", {31'b0, bus.PENABLE}, 0);
    check("midrst_busy", {31'b0, busy}, 0);
    check("midrst_q_empty", exp_q.size(), 0);
    exp_q.delete();
    @(negedge PCLK);
    PRESETn  = 1'b1;
    req_data = 16'h7700;
    push_txn(1'b1, 8'h77, 0);
    req = 2'b10;
    run_until_rsp(1);
    wait_drain();

    // Request set changes 01 -> 11 while busy: no grant before RESP.
    wait_states = 0;
    req_data    = 16'h2211;
    push_txn(1'b0, 8'h11, 0);
`ifdef UART_SEQ_RR_EN
    push_txn(1'b1, 8'h22, 0);
`else
    push_txn(1'b0, 8'h11, 0);
`endif
    req   = 2'b01;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge PCLK);
      if (gnt != 2'b00) found = 1'b1;
    end
    check("first_gnt_seen", {31'b0, found}, 1);
    req = 2'b11;
    run_until_rsp(2);
    wait_drain();

    repeat (3) @(negedge PCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
